// File: rtl/aclk_pkg.sv
// Shared constants, FSM state type and BCD-to-ASCII helper for the alarm-clock LCD controller.
package aclk_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_ERR   = 8'h45;
    localparam logic [7:0] ASCII_BLANK = 8'h20;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RING = 1'b1
    } ring_state_e;

    // Non-decimal nibbles show as 'E' so a corrupted time is visible on the panel.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
        logic [7:0] res;
        if (digit <= 4'd9) begin
            res = ASCII_ZERO + {4'h0, digit};
        end else begin
            res = ASCII_ERR;
        end
        return res;
    endfunction

endpackage

// File: rtl/aclk_digit_encoder.sv
// Combinational encoder of one BCD digit into its ASCII character.
module aclk_digit_encoder
    import aclk_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = bcd_to_ascii(bcd);
    end

endmodule

// File: rtl/aclk_lcd_display_ctrl.sv
// LCD display controller: time-source mux, ASCII encoding with entry blink, and alarm-ring FSM.
module aclk_lcd_display_ctrl
    import aclk_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned ALARM_TICKS = 60
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      one_second,
    input  logic                      show_a,
    input  logic                      show_new_time,
    input  logic                      alarm_en,
    input  logic                      stop_alarm,
    input  logic [4*NUM_DIGITS-1:0]   alarm_time,
    input  logic [4*NUM_DIGITS-1:0]   current_time,
    input  logic [4*NUM_DIGITS-1:0]   key_time,
    output logic [8*NUM_DIGITS-1:0]   display_time,
    output logic                      sound_alarm
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned AW = 8 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(ALARM_TICKS + 1);

    logic [DW-1:0] src_time;
    logic [AW-1:0] enc_time;
    logic [AW-1:0] disp_d, disp_q;
    logic          blink_d, blink_q;
    logic          match, match_d_q, rise;
    ring_state_e   state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          sound_d, sound_q;

    always_comb begin
        if (show_new_time) begin
            src_time = key_time;
        end else if (show_a) begin
            src_time = alarm_time;
        end else begin
            src_time = current_time;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        aclk_digit_encoder u_enc (
            .bcd   (src_time[4*g +: 4]),
            .ascii (enc_time[8*g +: 8])
        );
    end

    // Blanking uses the next phase so a tick changes the panel with one clock of latency.
    always_comb begin
        blink_d = 1'b0;
        if (show_new_time) begin
            blink_d = one_second ? ~blink_q : blink_q;
        end
        disp_d = (show_new_time && blink_d) ? {NUM_DIGITS{ASCII_BLANK}} : enc_time;
    end

    always_comb begin
        match = alarm_en && (alarm_time == current_time);
        rise  = match && !match_d_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rise && !stop_alarm) begin
                    state_d = ST_RING;
                    cnt_d   = CW'(ALARM_TICKS);
                end
            end
            ST_RING: begin
                if (stop_alarm || !alarm_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (one_second) begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sound_d = (state_d == ST_RING);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_q    <= {NUM_DIGITS{ASCII_ZERO}};
            blink_q   <= 1'b0;
            match_d_q <= 1'b0;
            sound_q   <= 1'b0;
        end else begin
            disp_q    <= disp_d;
            blink_q   <= blink_d;
            match_d_q <= match;
            sound_q   <= sound_d;
        end
    end

    assign display_time = disp_q;
    assign sound_alarm  = sound_q;

endmodule

// File: tb/tb_aclk_lcd_display_ctrl.sv
// Scoreboard bench: stimulus queues expected outputs per cycle, a negedge monitor compares them.
module tb_aclk_lcd_display_ctrl;

    typedef struct {
        int          cyc;
        string       name;
        bit          cd;
        logic [31:0] disp;
        bit          cs;
        logic        snd;
        bit          cs1;
        logic        snd1;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        one_second = 1'b0;
    logic        show_a = 1'b0;
    logic        show_new_time = 1'b0;
    logic        alarm_en = 1'b0;
    logic        stop_alarm = 1'b0;
    logic [15:0] alarm_time = '0;
    logic [15:0] current_time = '0;
    logic [15:0] key_time = '0;
    logic [31:0] display_time, display_time1;
    logic        sound_alarm, sound_alarm1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;

    aclk_lcd_display_ctrl #(.NUM_DIGITS(4), .ALARM_TICKS(60)) dut (
        .clock(clock), .reset(reset), .one_second(one_second), .show_a(show_a),
        .show_new_time(show_new_time), .alarm_en(alarm_en), .stop_alarm(stop_alarm),
        .alarm_time(alarm_time), .current_time(current_time), .key_time(key_time),
        .display_time(display_time), .sound_alarm(sound_alarm)
    );

    aclk_lcd_display_ctrl #(.NUM_DIGITS(4), .ALARM_TICKS(1)) dut1 (
        .clock(clock), .reset(reset), .one_second(one_second), .show_a(show_a),
        .show_new_time(show_new_time), .alarm_en(alarm_en), .stop_alarm(stop_alarm),
        .alarm_time(alarm_time), .current_time(current_time), .key_time(key_time),
        .display_time(display_time1), .sound_alarm(sound_alarm1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s stale expectation for cycle %0d seen at %0d", mon_e.name, mon_e.cyc, cyc);
            end else begin
                if (mon_e.cd) begin
                    checks++;
                    if (display_time !== mon_e.disp) begin
                        errors++;
                        $display("FAIL %s display_time got %h expected %h", mon_e.name, display_time, mon_e.disp);
                    end
                end
                if (mon_e.cs) begin
                    checks++;
                    if (sound_alarm !== mon_e.snd) begin
                        errors++;
                        $display("FAIL %s sound_alarm got %b expected %b", mon_e.name, sound_alarm, mon_e.snd);
                    end
                end
                if (mon_e.cs1) begin
                    checks++;
                    if (sound_alarm1 !== mon_e.snd1) begin
                        errors++;
                        $display("FAIL %s sound_alarm(ticks=1) got %b expected %b", mon_e.name, sound_alarm1, mon_e.snd1);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int ofs, input string nm, input bit cd, input logic [31:0] d,
                        input bit cs, input logic s, input bit cs1, input logic s1);
        exp_t e;
        e.cyc  = cyc + ofs;
        e.name = nm;
        e.cd   = cd;
        e.disp = d;
        e.cs   = cs;
        e.snd  = s;
        e.cs1  = cs1;
        e.snd1 = s1;
        q.push_back(e);
    endtask

    task automatic exp_d(input string nm, input logic [31:0] d);
        push(1, nm, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exp_s(input string nm, input logic s, input logic s1);
        push(1, nm, 1'b0, '0, 1'b1, s, 1'b1, s1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        push(1, "reset_state", 1'b1, 32'h30303030, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        reset = 1'b1;

        current_time = 16'h1234;
        exp_d("current_1234", 32'h31323334);
        step();
        show_a = 1'b1;
        alarm_time = 16'h0630;
        exp_d("show_alarm_0630", 32'h30363330);
        step();
        alarm_time = 16'h0B30;
        exp_d("digit_B_err", 32'h30453330);
        step();
        alarm_time = 16'hFA9C;
        exp_d("digits_mixed_err", 32'h45453945);
        step();

        show_new_time = 1'b1;
        key_time = 16'h0945;
        exp_d("key_entry", 32'h30393435);
        step();
        one_second = 1'b1;
        exp_d("blink_off_tick1", 32'h20202020);
        step();
        one_second = 1'b0;
        exp_d("blink_hold_blank", 32'h20202020);
        step();
        one_second = 1'b1;
        exp_d("blink_on_tick2", 32'h30393435);
        step();
        one_second = 1'b0;
        exp_d("blink_hold_shown", 32'h30393435);
        step();
        one_second = 1'b1;
        exp_d("blink_off_tick3", 32'h20202020);
        step();
        one_second = 1'b0;
        show_new_time = 1'b0;
        show_a = 1'b0;
        exp_d("entry_dropped", 32'h31323334);
        step();
        show_new_time = 1'b1;
        exp_d("phase_cleared", 32'h30393435);
        step();
        show_new_time = 1'b0;
        step();

        alarm_en = 1'b1;
        alarm_time = 16'h0630;
        current_time = 16'h0629;
        exp_s("pre_match_silent", 1'b0, 1'b0);
        step();
        current_time = 16'h0630;
        push(1, "match_rings", 1'b1, 32'h30363330, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        for (int i = 1; i <= 60; i++) begin
            one_second = 1'b1;
            exp_s("ring_tick", (i < 60), 1'b0);
            step();
            one_second = 1'b0;
            exp_s("ring_between", (i < 60), 1'b0);
            step();
        end
        exp_s("no_retrigger", 1'b0, 1'b0);
        step();
        one_second = 1'b1;
        exp_s("no_retrigger_tick", 1'b0, 1'b0);
        step();
        one_second = 1'b0;
        step();

        current_time = 16'h0631;
        exp_s("match_fell", 1'b0, 1'b0);
        step();
        current_time = 16'h0630;
        exp_s("rering", 1'b1, 1'b1);
        step();
        stop_alarm = 1'b1;
        exp_s("stop_silences", 1'b0, 1'b0);
        step();
        stop_alarm = 1'b0;
        exp_s("stop_no_retrigger", 1'b0, 1'b0);
        step();
        current_time = 16'h0631;
        step();
        current_time = 16'h0630;
        stop_alarm = 1'b1;
        exp_s("rise_with_stop", 1'b0, 1'b0);
        step();
        stop_alarm = 1'b0;
        exp_s("after_rise_with_stop", 1'b0, 1'b0);
        step();
        current_time = 16'h0631;
        step();
        current_time = 16'h0630;
        exp_s("ring_for_disarm", 1'b1, 1'b1);
        step();
        alarm_en = 1'b0;
        exp_s("disarm_silences", 1'b0, 1'b0);
        step();
        alarm_en = 1'b1;
        current_time = 16'h0631;
        step();

        current_time = 16'h0630;
        exp_s("ring_before_reset", 1'b1, 1'b1);
        step();
        step();
        push(0, "async_reset", 1'b1, 32'h30303030, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_s("ring_after_reset", 1'b1, 1'b1);
        step();
        one_second = 1'b1;
        exp_s("single_tick_ring", 1'b1, 1'b0);
        step();
        one_second = 1'b0;
        exp_s("single_tick_done", 1'b1, 1'b0);
        step();

        repeat (3) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
